// File: rtl/breakout_pkg.sv
// Shared Breakout constants and the ball state encoding.
package breakout_pkg;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int BALL_SIZE  = 8;
    localparam int PADDLE_Y   = 440;
    localparam int PADDLE_W   = 64;
    localparam int LIVES_INIT = 3;

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        LOST,
        GAME_OVER
    } state_t;

endpackage

// File: rtl/ball_motion_rise_detect.sv
// Registered rising-edge detector: one-cycle pulse per low-to-high transition of din.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            prev  <= din;
            pulse <= din & ~prev;
        end
    end

endmodule

// File: rtl/ball_motion.sv
// Breakout ball: per-tick motion, wall/paddle/brick bounces, serves, lost balls and lives.
module ball_motion
    import breakout_pkg::*;
#(
    parameter int SPEED   = 2,
    parameter int START_X = 316,
    parameter int START_Y = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       serve_btn,
    input  logic [9:0] paddle_x,
    input  logic       brick_hit,
    input  logic       brick_side,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       ball_active,
    output logic       ball_lost,
    output logic [1:0] lives,
    output logic       game_over
);

    localparam logic signed [10:0] STEP    = 11'(SPEED);
    localparam logic signed [10:0] MAX_X   = 11'(SCREEN_W - BALL_SIZE);
    localparam logic signed [10:0] MAX_Y   = 11'(SCREEN_H - BALL_SIZE);
    localparam logic signed [10:0] PAD_LIM = 11'(PADDLE_Y - BALL_SIZE);

    state_t            state, state_nxt;
    logic [9:0]        x_q, y_q, x_nxt, y_nxt;
    logic              dx_q, dy_q, dx_nxt, dy_nxt;   // dx_q=1: +x, dy_q=1: down
    logic              dx_eff, dy_eff;
    logic              flip_x_q, flip_y_q, flip_x_nxt, flip_y_nxt;
    logic [1:0]        lives_q, lives_nxt;
    logic signed [10:0] nx, ny;
    logic              over_paddle;
    logic              tick_rise, serve_rise;

    rise_detect u_tick_rise (
        .clk   (clk),
        .reset (reset),
        .din   (tick),
        .pulse (tick_rise)
    );

    rise_detect u_serve_rise (
        .clk   (clk),
        .reset (reset),
        .din   (serve_btn),
        .pulse (serve_rise)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            x_q      <= 10'(START_X);
            y_q      <= 10'(START_Y);
            dx_q     <= 1'b1;
            dy_q     <= 1'b0;
            flip_x_q <= 1'b0;
            flip_y_q <= 1'b0;
            lives_q  <= 2'(LIVES_INIT);
        end else begin
            state    <= state_nxt;
            x_q      <= x_nxt;
            y_q      <= y_nxt;
            dx_q     <= dx_nxt;
            dy_q     <= dy_nxt;
            flip_x_q <= flip_x_nxt;
            flip_y_q <= flip_y_nxt;
            lives_q  <= lives_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        x_nxt     = x_q;
        y_nxt     = y_q;
        dx_nxt    = dx_q;
        dy_nxt    = dy_q;
        lives_nxt = lives_q;

        dx_eff = dx_q ^ flip_x_q;
        dy_eff = dy_q ^ flip_y_q;
        nx     = $signed({1'b0, x_q}) + (dx_eff ? STEP : -STEP);
        ny     = $signed({1'b0, y_q}) + (dy_eff ? STEP : -STEP);
        over_paddle = ({2'b00, x_q} + 12'(BALL_SIZE) > {2'b00, paddle_x}) &&
                      ({2'b00, x_q} < {2'b00, paddle_x} + 12'(PADDLE_W));

        // Flags clear on the update that consumes them; a hit in that same cycle re-arms them.
        flip_x_nxt = (state == MOVE && !tick_rise) ? flip_x_q : 1'b0;
        flip_y_nxt = (state == MOVE && !tick_rise) ? flip_y_q : 1'b0;
        if (state == MOVE && brick_hit) begin
            if (brick_side) flip_x_nxt = 1'b1;
            else            flip_y_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                if (serve_rise) state_nxt = MOVE;
            end
            MOVE: begin
                if (tick_rise) begin
                    dx_nxt = dx_eff;
                    dy_nxt = dy_eff;
                    if (nx[10]) begin
                        x_nxt  = '0;
                        dx_nxt = 1'b1;
                    end else if (nx > MAX_X) begin
                        x_nxt  = MAX_X[9:0];
                        dx_nxt = 1'b0;
                    end else begin
                        x_nxt = nx[9:0];
                    end

                    if (ny[10]) begin
                        y_nxt  = '0;
                        dy_nxt = 1'b1;
                    end else if (dy_eff && ny > PAD_LIM &&
                                 $signed({1'b0, y_q}) <= PAD_LIM && over_paddle) begin
                        y_nxt  = PAD_LIM[9:0];
                        dy_nxt = 1'b0;
                    end else if (ny > MAX_Y) begin
                        state_nxt = LOST;
                        x_nxt     = x_q;
                        y_nxt     = y_q;
                    end else begin
                        y_nxt = ny[9:0];
                    end
                end
            end
            LOST: begin
                lives_nxt = lives_q - 2'd1;
                if (lives_q == 2'd1) begin
                    state_nxt = GAME_OVER;
                end else begin
                    state_nxt = IDLE;
                    x_nxt     = 10'(START_X);
                    y_nxt     = 10'(START_Y);
                    dx_nxt    = 1'b1;
                    dy_nxt    = 1'b0;
                end
            end
            GAME_OVER: begin
                if (serve_rise) begin
                    state_nxt = IDLE;
                    lives_nxt = 2'(LIVES_INIT);
                    x_nxt     = 10'(START_X);
                    y_nxt     = 10'(START_Y);
                    dx_nxt    = 1'b1;
                    dy_nxt    = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ball_x      = x_q;
    assign ball_y      = y_q;
    assign lives       = lives_q;
    assign ball_active = (state == MOVE);
    assign ball_lost   = (state == LOST);
    assign game_over   = (state == GAME_OVER);

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: trajectories, bounces, losses, lives and reset.
module tb_ball_motion;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       serve_btn;
    logic [9:0] paddle_x;
    logic       brick_hit;
    logic       brick_side;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       ball_active;
    logic       ball_lost;
    logic [1:0] lives;
    logic       game_over;

    int tests_run    = 0;
    int tests_failed = 0;
    int lost_count   = 0;

    ball_motion dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .serve_btn   (serve_btn),
        .paddle_x    (paddle_x),
        .brick_hit   (brick_hit),
        .brick_side  (brick_side),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .ball_active (ball_active),
        .ball_lost   (ball_lost),
        .lives       (lives),
        .game_over   (game_over)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    always @(negedge clk) if (ball_lost === 1'b1) lost_count++;

    task automatic do_tick(input int hold);
        @(negedge clk) tick = 1'b1;
        repeat (hold) @(negedge clk);
        tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick(2);
    endtask

    task automatic do_serve();
        @(negedge clk) serve_btn = 1'b1;
        repeat (2) @(negedge clk);
        serve_btn = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_brick(input logic side);
        @(negedge clk);
        brick_hit  = 1'b1;
        brick_side = side;
        @(negedge clk) brick_hit = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_pos(input string name, input int ex, input int ey);
        tests_run++;
        if (ball_x !== 10'(ex) || ball_y !== 10'(ey)) begin
            tests_failed++;
            $display("FAIL %s: got (%0d,%0d) want (%0d,%0d)", name, ball_x, ball_y, ex, ey);
        end
    endtask

    task automatic check_flags(input string name, input logic ea, input logic [1:0] el,
                               input logic eg);
        tests_run++;
        if (ball_active !== ea || lives !== el || game_over !== eg || ball_lost !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s: got active=%b lives=%0d game_over=%b lost=%b want %b %0d %b 0",
                     name, ball_active, lives, game_over, ball_lost, ea, el, eg);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        check_pos("reset_pos", 316, 300);
        check_flags("reset_flags", 1'b0, 2'd3, 1'b0);
        do_tick(2);
        check_pos("idle_tick_ignored", 316, 300);
        do_serve();
        check_flags("serve_active", 1'b1, 2'd3, 1'b0);
        check_pos("serve_pos", 316, 300);
    endtask

    task automatic test_walls();
        run_ticks(150);
        check_pos("tick150", 616, 0);
        do_tick(2);
        check_pos("tick151_top", 618, 0);
        do_tick(2);
        check_pos("tick152_down", 620, 2);
        run_ticks(6);
        check_pos("tick158", 632, 14);
        do_tick(2);
        check_pos("tick159_right", 632, 16);
        do_tick(2);
        check_pos("tick160_left", 630, 18);
    endtask

    task automatic test_tick_held();
        do_tick(10);
        check_pos("held_tick_once", 628, 20);
    endtask

    task automatic test_lost();
        int lc;
        paddle_x = 10'd0;
        run_ticks(226);
        check_pos("tick387_bottom", 176, 472);
        lc = lost_count;
        do_tick(2);
        tests_run++;
        if (lost_count - lc !== 1) begin
            tests_failed++;
            $display("FAIL lost_pulse: got %0d cycles want 1", lost_count - lc);
        end
        check_flags("after_loss", 1'b0, 2'd2, 1'b0);
        check_pos("after_loss_pos", 316, 300);
        do_tick(2);
        check_pos("idle_after_loss", 316, 300);
    endtask

    task automatic test_paddle();
        int lc;
        lc = lost_count;
        paddle_x = 10'd200;
        do_serve();
        run_ticks(367);
        check_pos("tick367_above_paddle", 216, 432);
        do_tick(2);
        check_pos("tick368_paddle", 214, 432);
        do_tick(2);
        check_pos("tick369_up", 212, 430);
        tests_run++;
        if (lost_count !== lc || ball_active !== 1'b1) begin
            tests_failed++;
            $display("FAIL paddle_no_loss: got lost=%0d active=%b want 0 1",
                     lost_count - lc, ball_active);
        end
    endtask

    task automatic test_brick();
        pulse_brick(1'b0);
        pulse_brick(1'b0);
        check_pos("brick_latched_only", 212, 430);
        do_tick(2);
        check_pos("brick_dy_once", 210, 432);
        pulse_brick(1'b1);
        do_tick(2);
        check_pos("brick_dx_and_paddle", 212, 432);
        do_tick(2);
        check_pos("after_brick_dx", 214, 430);
    endtask

    task automatic test_game_over();
        int lc;
        apply_reset();
        paddle_x = 10'd0;
        for (int i = 0; i < 3; i++) begin
            do_serve();
            run_ticks(387);
            lc = lost_count;
            do_tick(2);
            tests_run++;
            if (lost_count - lc !== 1 || lives !== 2'(2 - i)) begin
                tests_failed++;
                $display("FAIL loss_%0d: got pulses=%0d lives=%0d want 1 %0d",
                         i, lost_count - lc, lives, 2 - i);
            end
        end
        check_flags("game_over_state", 1'b0, 2'd0, 1'b1);
        check_pos("game_over_pos", 176, 472);
        run_ticks(3);
        check_pos("game_over_frozen", 176, 472);
        do_serve();
        check_flags("restart", 1'b0, 2'd3, 1'b0);
        check_pos("restart_pos", 316, 300);
    endtask

    task automatic test_reset_mid_move();
        do_serve();
        run_ticks(5);
        check_pos("move5", 326, 290);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_pos("async_reset_pos", 316, 300);
        check_flags("async_reset_flags", 1'b0, 2'd3, 1'b0);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        do_tick(2);
        check_pos("post_reset_idle", 316, 300);
    endtask

    initial begin
        reset      = 1'b1;
        tick       = 1'b0;
        serve_btn  = 1'b0;
        paddle_x   = 10'd0;
        brick_hit  = 1'b0;
        brick_side = 1'b0;
        test_reset();
        test_walls();
        test_tick_held();
        test_lost();
        test_paddle();
        test_brick();
        test_game_over();
        test_reset_mid_move();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ball_motion.md
Name: ball_motion

Overview:
Downstream consumer of the frame-rate refresh tick. Once per tick it advances the Breakout ball position by a fixed velocity and resolves bounces off walls, paddle and bricks. It also tracks serves, lost balls and lives. Outputs feed the pixel/object renderer and the brick-map collision logic.

Parameters:
SCREEN_W, 640, active width in pixels
SCREEN_H, 480, active height in pixels
BALL_SIZE, 8, ball edge length (square)
SPEED, 2, pixels moved per axis per tick
PADDLE_Y, 440, top row of paddle
PADDLE_W, 64, paddle width
START_X, 316, ball x after reset/serve reload
START_Y, 300, ball y after reset/serve reload
LIVES_INIT, 3, lives loaded at reset and restart

Ports:
clk  in  1  system clock, 125 MHz
reset  in  1  asynchronous, active-high
tick  in  1  refresh tick pulse; one update per rising edge
serve_btn  in  1  serve/restart request, already synchronized and debounced
paddle_x  in  10  paddle left edge
brick_hit  in  1  one-cycle collision pulse from brick logic
brick_side  in  1  qualifies brick_hit: 0 = flip dy, 1 = flip dx
ball_x  out  10  ball left edge
ball_y  out  10  ball top edge
ball_active  out  1  high in MOVE
ball_lost  out  1  one-cycle pulse when the ball exits the bottom
lives  out  2  remaining lives
game_over  out  1  high in GAME_OVER

Behaviour:
- Interface: one clock, clk. Reset port reset is asynchronous and active-high.
- Reset values:
  - ball_x=START_X, ball_y=START_Y, dx=+1, dy=-1 (up)
  - lives=LIVES_INIT, state IDLE
  - ball_active=0, ball_lost=0, game_over=0, brick flags cleared
- Edge detection:
  - tick and serve_btn are rising-edge detected internally via registered previous value.
  - A tick held high for several cycles counts once.
- Update latency: registers update on the clock edge after the cycle where the tick rise is detected. ball_x/ball_y are visible 1 cycle after that.
- Brick latch:
  - brick_hit is latched (flip_x/flip_y flags) until the next tick update, where it is applied and cleared.
  - Multiple hits between ticks on the same axis flip that axis once.
- States:
  - IDLE: ball parked at START. serve_btn rise -> MOVE.
  - MOVE: per-tick update (below).
  - LOST: one cycle. ball_lost=1, lives decremented. Go to GAME_OVER if lives becomes 0, else IDLE with position reloaded to START and dx=+1, dy=-1.
  - GAME_OVER: game_over=1, position frozen. serve_btn rise -> IDLE with lives=LIVES_INIT and START reload.
- Per-tick update order in MOVE:
  1. Apply latched brick flips to dx/dy.
  2. X axis: nx = x + dx*SPEED, computed 11-bit signed.
     - nx<0 -> x=0, dx=+1.
     - nx>SCREEN_W-BALL_SIZE -> x=SCREEN_W-BALL_SIZE, dx=-1.
     - Otherwise x=nx.
  3. Y axis: ny = y + dy*SPEED.
     - ny<0 -> y=0, dy=+1.
     - Paddle bounce: dy=+1, and ny+BALL_SIZE>PADDLE_Y, and y+BALL_SIZE<=PADDLE_Y, and ball x overlaps [paddle_x, paddle_x+PADDLE_W) -> y=PADDLE_Y-BALL_SIZE, dy=-1.
     - ny>SCREEN_H-BALL_SIZE -> go to LOST, position held.
     - Otherwise y=ny.
  4. Paddle overlap uses the pre-update x.
- Boundary rules:
  - A corner hit flips both axes on the same tick.
  - brick_hit arriving in the same cycle as the tick rise is applied on the following tick.
  - serve_btn in MOVE/LOST is ignored.
  - Ticks in IDLE/GAME_OVER are ignored.
  - Reset mid-MOVE returns immediately to reset values.

Decomposition:
- Shared package breakout_pkg holds:
  - SCREEN_W/SCREEN_H
  - BALL_SIZE
  - PADDLE_Y/PADDLE_W
  - LIVES_INIT
  - state encoding: IDLE, MOVE, LOST, GAME_OVER
- Sub-module rise_detect (registered rising-edge pulse), instantiated twice: tick and serve_btn.

Test Plan:
- Reset, then serve, then 151 ticks:
  - tick 150: x=616, y=0
  - tick 151: x=618, y=0, dy=+1
  - tick 152: y=2
- Continue the same run:
  - tick 158: x=632
  - tick 159: x=632, dx=-1
  - tick 160: x=630
- paddle_x=0 held while the ball descends far right:
  - ball_lost pulses one cycle
  - lives 3->2, ball_active=0
  - ball at (316,300), state IDLE
- paddle_x placed under the descending ball:
  - ball lands at y=432, dy=-1
  - no ball_lost
- brick_hit with brick_side=0 pulsed twice between ticks: dy flips once on the next tick.
- Three consecutive losses, then serve_btn:
  - after the losses: game_over=1, lives=0, ticks ignored
  - serve_btn rise -> IDLE, lives=3
- Additional checks:
  - tick held high 10 cycles -> exactly one update
  - reset asserted mid-MOVE -> all outputs return to reset values asynchronously
